// File: rtl/piso_serializer.sv
// Parallel-in, serial-out buffer: words queue in a small FIFO, then shift out
// LANES bits per beat with a per-word beat count and bit order.
module piso_serializer #(
    parameter int  DATA_BITS = 8,
    parameter int  LANES     = 1,
    parameter int  DEPTH     = 2,
    localparam int BEATS     = DATA_BITS / LANES,
    localparam int LEN_BITS  = $clog2(BEATS + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 input_valid,
    input  logic [DATA_BITS-1:0] input_data,
    input  logic [LEN_BITS-1:0]  input_beats,
    input  logic                 input_msb_first,
    output logic                 input_ready,
    output logic                 output_valid,
    output logic [LANES-1:0]     output_data,
    output logic                 output_last,
    input  logic                 output_ready,
    output logic                 busy
);

    localparam int PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BITS = $clog2(DEPTH + 1);
    localparam logic [LEN_BITS-1:0] FULL_LEN  = LEN_BITS'(BEATS);
    localparam logic [LEN_BITS-1:0] ONE_LEN   = LEN_BITS'(1);
    localparam logic [PTR_BITS-1:0] LAST_PTR  = PTR_BITS'(DEPTH - 1);
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);

    logic [DATA_BITS-1:0] q_data  [DEPTH];
    logic [LEN_BITS-1:0]  q_beats [DEPTH];
    logic [DEPTH-1:0]     q_msb;
    logic [PTR_BITS-1:0]  head;
    logic [PTR_BITS-1:0]  tail;
    logic [CNT_BITS-1:0]  count;

    logic [DATA_BITS-1:0] buffer;
    logic [LEN_BITS-1:0]  remaining;
    logic                 msb_first;
    logic                 loaded;

    logic [LEN_BITS-1:0]  norm_beats;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_fire;
    logic                 free;
    logic                 pop;
    logic                 bypass;
    logic                 push;

    assign input_ready = (count < DEPTH_CNT);
    assign norm_beats  = ((input_beats == '0) || (input_beats > FULL_LEN)) ? FULL_LEN : input_beats;
    assign in_fire     = input_valid && input_ready;
    assign out_fire    = loaded && output_ready;
    assign last_fire   = out_fire && (remaining == ONE_LEN);
    assign free        = !loaded || last_fire;
    assign pop         = free && (count != '0);
    assign bypass      = free && (count == '0) && in_fire;
    assign push        = in_fire && !bypass;

    // Queue storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_data[tail]  <= input_data;
            q_beats[tail] <= norm_beats;
            q_msb[tail]   <= input_msb_first;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= (tail == LAST_PTR) ? '0 : tail + PTR_BITS'(1);
            end
            if (pop) begin
                head <= (head == LAST_PTR) ? '0 : head + PTR_BITS'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_BITS'(1);
            end else if (pop && !push) begin
                count <= count - CNT_BITS'(1);
            end
        end
    end

    // A finishing word hands over to the next one on the same edge, so beats
    // stay contiguous across word boundaries.
    always_ff @(posedge clk) begin
        if (rst) begin
            buffer    <= '0;
            remaining <= '0;
            msb_first <= 1'b0;
            loaded    <= 1'b0;
        end else if (pop) begin
            buffer    <= q_data[head];
            remaining <= q_beats[head];
            msb_first <= q_msb[head];
            loaded    <= 1'b1;
        end else if (bypass) begin
            buffer    <= input_data;
            remaining <= norm_beats;
            msb_first <= input_msb_first;
            loaded    <= 1'b1;
        end else if (last_fire) begin
            buffer    <= '0;
            remaining <= '0;
            loaded    <= 1'b0;
        end else if (out_fire) begin
            buffer    <= msb_first ? (buffer << LANES) : (buffer >> LANES);
            remaining <= remaining - ONE_LEN;
        end
    end

    always_comb begin
        output_data = '0;
        if (loaded) begin
            output_data = msb_first ? buffer[DATA_BITS-1 -: LANES] : buffer[LANES-1:0];
        end
    end

    assign output_valid = loaded;
    assign output_last  = loaded && (remaining == ONE_LEN);
    assign busy         = loaded || (count != '0);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a 1-lane and a 2-lane instance checked every
// cycle against a word-level model of beats and occupancy.
module tb_piso_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       iv0 = 1'b0, im0 = 1'b0, or0 = 1'b0;
    logic [7:0] id0 = '0;
    logic [3:0] ib0 = '0;
    logic       ir0, ov0, ol0, bz0;
    logic [0:0] od0;

    logic       iv1 = 1'b0, im1 = 1'b0, or1 = 1'b0;
    logic [7:0] id1 = '0;
    logic [2:0] ib1 = '0;
    logic       ir1, ov1, ol1, bz1;
    logic [1:0] od1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    int n_words [2];
    int exq0[$], exq1[$];
    int cap0[$], cap1[$], capc1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    piso_serializer #(.DATA_BITS(8), .LANES(1), .DEPTH(2)) dut0 (
        .clk(clk), .rst(rst),
        .input_valid(iv0), .input_data(id0), .input_beats(ib0), .input_msb_first(im0),
        .input_ready(ir0), .output_valid(ov0), .output_data(od0), .output_last(ol0),
        .output_ready(or0), .busy(bz0)
    );

    piso_serializer #(.DATA_BITS(8), .LANES(2), .DEPTH(3)) dut1 (
        .clk(clk), .rst(rst),
        .input_valid(iv1), .input_data(id1), .input_beats(ib1), .input_msb_first(im1),
        .input_ready(ir1), .output_valid(ov1), .output_data(od1), .output_last(ol1),
        .output_ready(or1), .busy(bz1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: a word occupies the shifter while any word is in flight, the rest
    // wait in the queue; expected beats are computed from each accepted word.
    task automatic mon(input int id, input int lanes, input int depth, input logic rs,
                       input logic iv, input logic ir, input logic [7:0] idata,
                       input logic [3:0] ibeats, input logic imsb, input logic ov,
                       input logic ordy, input logic ol, input logic [7:0] od, input logic bz);
        int n, e, nb, sh, full, mask;
        bit have;
        n = n_words[id];
        full = 8 / lanes;
        mask = (1 << lanes) - 1;
        check($sformatf("valid%0d", id), ov, n > 0);
        check($sformatf("busy%0d", id), bz, n > 0);
        check($sformatf("ready%0d", id), ir, ((n > 0) ? n - 1 : 0) < depth);
        if (!ov) check($sformatf("idle_data%0d", id), od, 0);
        if (ov) begin
            have = (id == 0) ? (exq0.size() != 0) : (exq1.size() != 0);
            check($sformatf("beat_expected%0d", id), have, 1);
            if (have) begin
                e = (id == 0) ? exq0[0] : exq1[0];
                check($sformatf("data%0d", id), od, e & 'hFF);
                check($sformatf("last%0d", id), ol, e >> 8);
            end
        end
        if (rs) begin
            n = 0;
            if (id == 0) exq0.delete(); else exq1.delete();
        end else begin
            if (ov && ordy && have) begin
                e = (id == 0) ? exq0.pop_front() : exq1.pop_front();
                if ((e >> 8) != 0) n--;
                if (id == 0) cap0.push_back(e);
                else begin
                    cap1.push_back(e);
                    capc1.push_back(cyc);
                end
            end
            if (iv && ir) begin
                n++;
                nb = (ibeats == 0 || ibeats > full) ? full : int'(ibeats);
                for (int k = 0; k < nb; k++) begin
                    sh = imsb ? 8 - (k + 1) * lanes : k * lanes;
                    e = (int'(idata >> sh) & mask) | (((k == nb - 1) ? 1 : 0) << 8);
                    if (id == 0) exq0.push_back(e); else exq1.push_back(e);
                end
            end
        end
        n_words[id] = n;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, 1, 2, rst, iv0, ir0, id0, ib0, im0, ov0, or0, ol0, {7'b0, od0}, bz0);
            mon(1, 2, 3, rst, iv1, ir1, id1, {1'b0, ib1}, im1, ov1, or1, ol1, {6'b0, od1}, bz1);
        end
    end

    task automatic send0(input logic [7:0] d, input logic [3:0] b, input logic m);
        bit ok = 1'b0;
        iv0 = 1'b1; id0 = d; ib0 = b; im0 = m;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            ok = ir0;
        end
        check("send0_accept", ok, 1);
        @(posedge clk); #1;
        iv0 = 1'b0;
    endtask

    task automatic send1(input logic [7:0] d, input logic [2:0] b, input logic m);
        bit ok = 1'b0;
        iv1 = 1'b1; id1 = d; ib1 = b; im1 = m;
        for (int t = 0; t < 60 && !ok; t++) begin
            @(negedge clk);
            ok = ir1;
        end
        check("send1_accept", ok, 1);
        @(posedge clk); #1;
        iv1 = 1'b0;
    endtask

    task automatic wait_idle(input int id);
        bit done = 1'b0;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            done = (id == 0) ? !bz0 : !bz1;
        end
        check($sformatf("drain%0d", id), done, 1);
    endtask

    // Packs captured beats first-beat-most-significant, plus a matching last mask.
    task automatic pack_cap(input int id, input int lanes, output logic [31:0] seq,
                            output logic [31:0] lm, output int n);
        int e;
        seq = '0; lm = '0;
        n = (id == 0) ? cap0.size() : cap1.size();
        for (int i = 0; i < n; i++) begin
            e = (id == 0) ? cap0[i] : cap1[i];
            seq = (seq << lanes) | (e & 'hFF);
            lm = (lm << 1) | ((e >> 8) & 1);
        end
    endtask

    logic [31:0] seq, lm;
    int n, acc;

    initial begin
        n_words[0] = 0;
        n_words[1] = 0;
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        @(negedge clk);
        check("rst_valid", ov0, 0);
        check("rst_data", od0, 0);
        check("rst_last", ol0, 0);
        check("rst_busy", bz0, 0);
        check("rst_ready", ir0, 1);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_rst_valid", ov0, 0);
        check("post_rst_ready", ir1, 1);
        @(posedge clk); #1;

        or0 = 1'b1; or1 = 1'b1;
        cap0.delete();
        send0(8'hA5, 4'd0, 1'b0);
        @(negedge clk);
        check("latency_valid", ov0, 1);
        wait_idle(0);
        pack_cap(0, 1, seq, lm, n);
        check("a5_lsb_n", n, 8);
        check("a5_lsb_seq", seq, 32'hA5);
        check("a5_lsb_last", lm, 32'h01);

        @(posedge clk); #1 cap0.delete();
        send0(8'hA5, 4'd0, 1'b1);
        wait_idle(0);
        pack_cap(0, 1, seq, lm, n);
        check("a5_msb_n", n, 8);
        check("a5_msb_seq", seq, 32'hA5);

        @(posedge clk); #1 cap0.delete();
        send0(8'hA5, 4'd3, 1'b0);
        wait_idle(0);
        pack_cap(0, 1, seq, lm, n);
        check("a5_len3_n", n, 3);
        check("a5_len3_seq", seq, 32'h5);
        check("a5_len3_last", lm, 32'h1);

        @(posedge clk); #1 cap0.delete();
        send0(8'h81, 4'd15, 1'b1);
        wait_idle(0);
        pack_cap(0, 1, seq, lm, n);
        check("len_over_n", n, 8);
        check("len_over_seq", seq, 32'h81);

        @(posedge clk); #1 cap1.delete(); capc1.delete();
        send1(8'h1B, 3'd0, 1'b0);
        send1(8'hE4, 3'd0, 1'b0);
        wait_idle(1);
        pack_cap(1, 2, seq, lm, n);
        check("l2_n", n, 8);
        check("l2_seq", seq, 32'hE41B);
        check("l2_last", lm, 32'h11);
        if (n == 8) check("l2_no_gap", capc1[7] - capc1[0], 7);

        @(posedge clk); #1;
        or0 = 1'b0; acc = 0;
        for (int i = 0; i < 6; i++) begin
            iv0 = 1'b1; id0 = 8'($urandom); ib0 = 4'($urandom); im0 = 1'($urandom);
            @(negedge clk);
            if (ir0) acc++;
            @(posedge clk); #1;
        end
        iv0 = 1'b0;
        check("stall_accepted", acc, 3);
        @(negedge clk);
        check("stall_full_ready", ir0, 0);
        @(posedge clk); #1 or0 = 1'b1;
        wait_idle(0);

        @(posedge clk); #1 cap0.delete();
        send0(8'h3C, 4'd0, 1'b0);
        send0(8'hC3, 4'd0, 1'b1);
        for (int t = 0; t < 20 && cap0.size() < 2; t++) begin
            @(posedge clk); #1;
        end
        check("rst_point", cap0.size(), 2);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_valid", ov0, 0);
        check("midrst_busy", bz0, 0);
        check("midrst_ready", ir0, 1);
        repeat (12) @(negedge clk);
        check("midrst_no_residual", cap0.size(), 2);

        @(posedge clk); #1;
        for (int i = 0; i < 600; i++) begin
            iv0 = 1'($urandom); id0 = 8'($urandom); ib0 = 4'($urandom); im0 = 1'($urandom);
            or0 = ($urandom_range(0, 3) != 0);
            iv1 = 1'($urandom); id1 = 8'($urandom); ib1 = 3'($urandom); im1 = 1'($urandom);
            or1 = ($urandom_range(0, 2) != 0);
            @(posedge clk); #1;
        end
        iv0 = 1'b0; iv1 = 1'b0; or0 = 1'b1; or1 = 1'b1;
        wait_idle(0);
        wait_idle(1);
        check("model_empty0", exq0.size(), 0);
        check("model_empty1", exq1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised next-generation parallel-in, serial-out buffer.
- Accepts parallel words on a valid/ready input and emits them LANES bits per beat on a valid/ready output.
- Per-word controls: beat count (variable length) and shift order (LSB-first or MSB-first).
- An input queue of DEPTH words lets consecutive words stream with no idle cycles between them.
- Sits between word-oriented producers and narrow serial links or line encoders.

Parameters:
- DATA_BITS, 8: parallel word width; must be a multiple of LANES.
- LANES, 1: bits emitted per output beat; 1 <= LANES <= DATA_BITS.
- DEPTH, 2: input queue entries; DEPTH >= 1.
- BEATS (derived, not overridable): DATA_BITS/LANES, beats in a full word.
- LEN_BITS (derived): $clog2(BEATS+1).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- input_valid  input  1  producer has a word
- input_data  input  DATA_BITS  parallel word
- input_beats  input  LEN_BITS  beats to emit; 0 or values > BEATS mean BEATS
- input_msb_first  input  1  1 = MSB-first order, 0 = LSB-first order
- input_ready  output  1  queue can accept a word
- output_valid  output  1  output_data holds a beat
- output_data  output  LANES  current beat
- output_last  output  1  current beat is the final beat of its word
- output_ready  input  1  consumer accepts the beat
- busy  output  1  queue non-empty or shifter loaded

Behaviour:
- Reset is rst: synchronous, active-high; clock is clk, all state updates on posedge clk.
- While rst is high and in the cycle after it deasserts:
  - queue is empty and the shifter is unloaded;
  - output_valid=0, output_data=0, output_last=0, busy=0, input_ready=1.
- Reset mid-word discards the partial word and all queued words; no further beats of them appear.
- Handshakes:
  - Input transfer happens when input_valid && input_ready.
  - Output transfer happens when output_valid && output_ready.
  - input_ready = queue count < DEPTH. It is registered state only and never depends on output_ready or input_valid in the same cycle.
  - output_valid, output_data and output_last are driven from registers only, with no combinational path from any input.
  - Once output_valid=1, output_data and output_last hold stable until the beat transfers.
- Shifter:
  - Registers: buffer[DATA_BITS], remaining-beat counter, order bit, loaded flag.
  - LSB-first: output_data = buffer[LANES-1:0]; after each beat, buffer shifts right by LANES with zero fill.
  - MSB-first: output_data = buffer[DATA_BITS-1 -: LANES]; after each beat, buffer shifts left by LANES with zero fill.
  - output_last = loaded && remaining == 1.
  - output_data = 0 whenever output_valid = 0.
- Load rule, evaluated each edge. The shifter is free if it is unloaded, or if its last beat transfers this cycle.
  - If free and the queue is non-empty, the queue head loads.
  - If free, the queue is empty and an input transfer occurs, the incoming word loads directly (bypass). Latency is 1 cycle: a word accepted at edge N drives output_valid=1 after edge N.
  - Otherwise the incoming word is written to the queue tail.
- Throughput: back-to-back words produce beats on consecutive cycles with no bubble between the last beat of one word and the first beat of the next.
- Queue ordering:
  - The queue is strict FIFO, with per-entry data, beats and order captured at acceptance.
  - Simultaneous push and pop keeps the count unchanged.
  - When full, input_ready=0 and the word is not accepted; the producer must hold.
- Counter arithmetic:
  - Beat count is normalised at acceptance: 0 or > BEATS becomes BEATS.
  - The remaining counter decrements only on output transfer and never wraps below 1 while loaded.
- Output stalls (output_ready=0) freeze the shifter; the queue continues to fill until full.
- busy = loaded || queue count != 0.

Test Plan:
- Reset, then input_data=8'hA5, beats=0, LSB-first, output_ready=1 -> output_valid is high 1 cycle after accept; beats 1,0,1,0,0,1,0,1 over 8 consecutive cycles; output_last only on the 8th; then busy=0.
- Same word with MSB-first -> beats 1,0,1,0,0,1,0,1 (A5 = 10100101, MSB first).
- Same word with input_msb_first=0 and input_beats=3 -> exactly 3 beats: 1,0,1; output_last on the 3rd.
- LANES=2: feed 8'h1B then 8'hE4 back-to-back, LSB-first -> 2-bit beats 3,2,1,0 then 0,1,2,3 on 8 consecutive cycles with no gap; output_last on beats 4 and 8.
- output_ready=0 held while pushing -> accepts DEPTH+1 words (1 in the shifter plus DEPTH queued), then input_ready=0. Release output_ready -> all words emerge in order with data unchanged.
- Assert rst in the middle of the 3rd beat of a word with another word queued -> next cycle output_valid=0, busy=0, input_ready=1; no residual beats appear after reset deasserts.
